// File: rtl/io_bus_uart_tx_responder.sv
// io_bus_uart_tx_responder: io-bridge bus responder with a byte TX FIFO, status/baud/control
// registers and an 8N1 UART transmitter.
module io_bus_uart_tx_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_address,
    input  logic        io_bus_enable,
    input  logic [1:0]  io_byte_enable,
    input  logic        io_rw,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        io_acknowledge,
    output logic        io_irq,
    output logic        uart_txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ACC_IDLE, ACK, WAIT_REL} acc_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_t;

    acc_t          acc_q, acc_d;
    tx_t           tx_q, tx_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, irq_q;
    logic [15:0]   div_q, div_d, per_q, per_d, cnt_q, cnt_d, rdata_q, rdata_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    idx_q, idx_d;
    logic          hit, start, wr, push_req, push, pop, full, empty, busy, bit_end;
    logic [2:0]    off;
    logic [15:0]   eff_div, status, rmux;
    logic          unused_bits;

    assign unused_bits = ^{io_byte_enable[1], io_address[0]};
    assign hit      = io_bus_enable && io_address[15:4] == BASE_ADDR[15:4];
    assign off      = io_address[3:1];
    assign start    = acc_q == ACC_IDLE && hit;
    assign wr       = start && !io_rw;
    assign full     = level_q == FULL_LVL;
    assign empty    = level_q == '0;
    assign busy     = tx_q != IDLE;
    assign eff_div  = div_q == '0 ? 16'd1 : div_q;
    assign bit_end  = busy && cnt_q == per_q - 16'd1;
    // A frame may be refilled straight out of its stop bit so frames run back to back.
    assign pop      = ctrl_q[0] && !empty && (tx_q == IDLE || (tx_q == STOP && bit_end));
    assign push_req = wr && off == 3'd0 && io_byte_enable[0];
    assign push     = push_req && (!full || pop);
    assign status   = {8'(level_q), 4'd0, ovf_q, full, empty, busy};
    assign rmux     = off == 3'd1 ? status :
                      off == 3'd2 ? div_q :
                      off == 3'd3 ? {14'd0, ctrl_q} : 16'd0;

    assign io_acknowledge = acc_q == ACK;
    assign io_read_data   = rdata_q;
    assign io_irq         = irq_q;
    assign uart_txd       = tx_q == START ? 1'b0 : tx_q == DATA ? sh_q[0] : 1'b1;

    always_comb begin
        acc_d   = acc_q == ACC_IDLE ? (hit ? ACK : ACC_IDLE) :
                  acc_q == ACK      ? WAIT_REL :
                  io_bus_enable     ? WAIT_REL : ACC_IDLE;
        rdata_d = start && io_rw ? rmux : 16'd0;
        div_d   = wr && off == 3'd2 ? io_write_data : div_q;
        ctrl_d  = wr && off == 3'd3 ? io_write_data[1:0] : ctrl_q;
        ovf_d   = (push_req && !push) || (ovf_q && !(wr && off == 3'd1 && io_write_data[3]));
        level_d = level_q + (push ? LVL_ONE : '0) - (pop ? LVL_ONE : '0);
    end

    always_comb begin
        tx_d  = tx_q;
        cnt_d = busy ? (bit_end ? 16'd0 : cnt_q + 16'd1) : cnt_q;
        per_d = bit_end ? eff_div : per_q;
        sh_d  = sh_q;
        idx_d = idx_q;
        if (bit_end) begin
            case (tx_q)
                START:   tx_d = DATA;
                DATA: begin
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + 3'd1;
                    tx_d  = idx_q == 3'd7 ? STOP : DATA;
                end
                default: tx_d = IDLE;
            endcase
        end
        if (pop) begin
            tx_d  = START;
            sh_d  = mem_q[rd_ptr_q];
            cnt_d = 16'd0;
            per_d = eff_div;
            idx_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= ACC_IDLE;
            tx_q     <= IDLE;
            rdata_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DEFAULT_DIV;
            ctrl_q   <= '0;
            per_q    <= 16'd1;
            cnt_q    <= '0;
            sh_q     <= '0;
            idx_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            tx_q     <= tx_d;
            rdata_q  <= rdata_d;
            wr_ptr_q <= push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            ctrl_q   <= ctrl_d;
            per_q    <= per_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            irq_q    <= ctrl_q[1] && empty && !busy;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= io_write_data[7:0];
    end
endmodule

// File: tb/tb_io_bus_uart_tx_responder.sv
// tb_io_bus_uart_tx_responder: directed and random bus traffic against a frame-level
// behavioural model of the responder, compared on every clock.
module tb_io_bus_uart_tx_responder;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, rw = 1'b0;
    logic [15:0] addr = '0, wd = '0;
    logic [1:0]  be = '0;
    logic [15:0] rd;
    logic        ack, irq, txd;
    int          n_chk = 0, n_fail = 0;
    bit          run_cmp = 1'b0;

    always #5 clk = ~clk;

    io_bus_uart_tx_responder #(.BASE_ADDR(16'h0000), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .reset(rst), .io_address(addr), .io_bus_enable(en), .io_byte_enable(be),
        .io_rw(rw), .io_write_data(wd), .io_read_data(rd), .io_acknowledge(ack),
        .io_irq(irq), .uart_txd(txd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file, byte queue and the frame currently on the wire.
    logic        m_ack, m_hold, m_ovf, m_on, m_irq;
    logic [15:0] m_rd, m_div;
    logic [1:0]  m_ctrl;
    logic [7:0]  m_q[$];
    logic [9:0]  m_frame;
    int          m_bit, m_cnt, m_len;

    function automatic int eff(input logic [15:0] d);
        return d == 16'd0 ? 1 : int'(d);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] o);
        logic [15:0] st;
        st = {8'(m_q.size()), 4'd0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, m_on};
        return o == 3'd1 ? st : o == 3'd2 ? m_div : o == 3'd3 ? {14'd0, m_ctrl} : 16'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack = 0; m_hold = 0; m_ovf = 0; m_on = 0; m_irq = 0; m_rd = 0;
            m_div = 16'd434; m_ctrl = 0; m_q.delete(); m_frame = '1;
            m_bit = 0; m_cnt = 0; m_len = 1;
        end else begin
            logic hit, strobe, pop, done, on_pre, irq_nx;
            logic [1:0]  ctrl_pre;
            logic [15:0] div_pre;
            logic [7:0]  b;
            int size_pre;
            hit = en && addr[15:4] == 12'h000;
            strobe = 0; pop = 0; done = 0;
            on_pre = m_on; ctrl_pre = m_ctrl; div_pre = m_div; size_pre = m_q.size();
            irq_nx = m_ctrl[1] && m_q.size() == 0 && !m_on;
            if (m_ack) begin
                m_ack = 0; m_hold = 1;
            end else if (m_hold) begin
                if (!en) m_hold = 0;
            end else if (hit) begin
                m_ack = 1; strobe = 1; m_rd = rw ? m_read(addr[3:1]) : 16'd0;
            end
            if (m_on) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_cnt = 0; m_len = eff(div_pre); m_bit++;
                    if (m_bit == 10) begin m_on = 0; done = 1; end
                end
            end
            if ((!on_pre || done) && ctrl_pre[0] && m_q.size() > 0) begin
                b = m_q.pop_front();
                m_frame = {1'b1, b, 1'b0};
                m_bit = 0; m_cnt = 0; m_len = eff(div_pre); m_on = 1; pop = 1;
            end
            if (strobe && !rw) begin
                if (addr[3:1] == 3'd0 && be[0]) begin
                    if (size_pre < DEPTH || pop) m_q.push_back(wd[7:0]);
                    else m_ovf = 1;
                end
                if (addr[3:1] == 3'd1 && wd[3]) m_ovf = 0;
                if (addr[3:1] == 3'd2) m_div = wd;
                if (addr[3:1] == 3'd3) m_ctrl = wd[1:0];
            end
            m_irq = irq_nx;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("ack", ack, m_ack);
            check("rdata", rd, m_ack ? m_rd : 16'h0);
            check("txd", txd, m_on ? m_frame[m_bit] : 1'b1);
            check("irq", irq, m_irq);
        end
    end

    task automatic bus(input logic [15:0] a, input logic r_w, input logic [15:0] d,
                       input logic [1:0] b, input bit want, output logic [15:0] r);
        int lat;
        @(negedge clk);
        addr = a; rw = r_w; wd = d; be = b; en = 1'b1; lat = -1; r = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack) begin lat = i; r = rd; break; end
        end
        en = 1'b0;
        check("ack_latency", lat, want ? 1 : -1);
        @(negedge clk);
    endtask

    logic [15:0] rv;
    logic [39:0] vec;
    logic        trace [0:400];
    int          k, acks;
    logic [7:0]  dec;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;
        check("rst_txd", txd, 1'b1);
        check("rst_ack", ack, 1'b0);
        check("rst_rdata", rd, 16'h0);
        check("rst_irq", irq, 1'b0);
        bus(16'h0002, 1, 0, 2'b11, 1, rv);
        check("status_after_reset", rv, 16'h0002);
        check("ack_width", ack, 1'b0);
        bus(16'h0004, 1, 0, 2'b11, 1, rv);
        check("baud_after_reset", rv, 16'd434);

        bus(16'h0004, 0, 16'd4, 2'b11, 1, rv);
        bus(16'h0006, 0, 16'd1, 2'b11, 1, rv);
        bus(16'h0000, 0, 16'h0055, 2'b01, 1, rv);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            vec[i] = txd;
        end
        check("frame_0x55", vec, 40'hF0F0F0F0F0);
        @(negedge clk);
        check("idle_after_frame", txd, 1'b1);

        bus(16'h0004, 0, 16'd2, 2'b11, 1, rv);
        bus(16'h0006, 0, 16'd0, 2'b11, 1, rv);
        for (int i = 0; i <= 16; i++) bus(16'h0000, 0, 16'(i), 2'b01, 1, rv);
        bus(16'h0002, 1, 0, 2'b11, 1, rv);
        check("status_full_ovf", rv, 16'h100C);
        bus(16'h0002, 0, 16'h0008, 2'b11, 1, rv);
        bus(16'h0002, 1, 0, 2'b11, 1, rv);
        check("status_ovf_cleared", rv, 16'h1004);

        bus(16'h0006, 0, 16'd3, 2'b11, 1, rv);
        k = 1;
        trace[1] = txd;
        while (!irq && k < 400) begin
            @(negedge clk);
            k++;
            trace[k] = txd;
        end
        check("irq_delay", k, 322);
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 8; i++) dec[i] = trace[1 + f * 20 + (i + 1) * 2];
            check("frame_byte", dec, 8'(f));
        end
        bus(16'h0006, 0, 16'd1, 2'b11, 1, rv);
        check("irq_cleared", irq, 1'b0);

        bus(16'h0006, 0, 16'd0, 2'b11, 1, rv);
        @(negedge clk);
        addr = 16'h0000; rw = 1'b0; wd = 16'h00F7; be = 2'b01; en = 1'b1; acks = 0;
        repeat (5) begin @(negedge clk); acks += int'(ack); end
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("held_enable_acks", acks, 1);
        bus(16'h0002, 1, 0, 2'b11, 1, rv);
        check("status_one_push", rv, 16'h0100);
        bus(16'h0100, 0, 16'h00AA, 2'b01, 0, rv);
        bus(16'h0002, 1, 0, 2'b11, 1, rv);
        check("status_other_window", rv, 16'h0100);

        bus(16'h0004, 0, 16'd4, 2'b11, 1, rv);
        bus(16'h0006, 0, 16'd1, 2'b11, 1, rv);
        repeat (17) @(negedge clk);
        check("data_bit3_low", txd, 1'b0);
        #2 rst = 1'b1;
        #1 check("txd_async_reset", txd, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus(16'h0002, 1, 0, 2'b11, 1, rv);
        check("status_after_midframe_reset", rv, 16'h0002);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] a, d;
            logic r;
            bit want;
            int sel;
            sel = $urandom_range(0, 19);
            a = {12'h000, 4'($urandom_range(0, 15))};
            r = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            want = 1;
            if (a[3:1] == 3'd2) d = 16'($urandom_range(0, 3));
            if (sel < 8) begin a = {15'd0, 1'($urandom_range(0, 1))}; r = 1'b0; end
            if (sel == 19) begin a = {12'($urandom_range(1, 4095)), 4'($urandom)}; want = 0; end
            bus(a, r, d, 2'($urandom), want, rv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus(16'h0006, 0, 16'd3, 2'b11, 1, rv);
        repeat (800) @(negedge clk);
        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
